// File: rtl/fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_pkg
//  Description : Shared defaults and the pointer-width helper for the
//                register-based FIFO (fifo_registros / fifo_ctrl).
//  Contents    : FIFO_N_DEF     - default data word width
//                FIFO_DEPTH_DEF - default number of storage words
//                ptr_width()    - address bits needed to index DEPTH words
//  Revision    : 1.0 - initial release
// ============================================================================
package fifo_pkg;

    localparam int FIFO_N_DEF     = 8;
    localparam int FIFO_DEPTH_DEF = 4;

    // DEPTH is a power of two >= 2, so this is always at least 1 bit and a
    // pointer of this width wraps modulo DEPTH on its own.
    function automatic int ptr_width(input int depth);
        return $clog2(depth);
    endfunction

endpackage : fifo_pkg
`default_nettype wire

// File: rtl/fifo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_ctrl
//  Description : Pointer, occupancy and status-flag controller for the
//                register-based FIFO. Storage lives in the parent.
//  Ports       : clk         - clock, rising edge
//                rst         - synchronous active-high reset
//                i_wr_en     - write request
//                i_rd_en     - read request
//                o_wr_accept - write accepted this cycle (storage write enable)
//                o_wr_ptr    - storage index for the next write
//                o_rd_ptr    - storage index of the head word
//                o_count     - number of stored words
//                o_full      - count == DEPTH
//                o_empty     - count == 0
//                o_ovf       - one-cycle pulse after a rejected write
//                o_udf       - one-cycle pulse after a rejected read
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_wr_en,
    input  logic                          i_rd_en,
    output logic                          o_wr_accept,
    output logic [ptr_width(DEPTH)-1:0]   o_wr_ptr,
    output logic [ptr_width(DEPTH)-1:0]   o_rd_ptr,
    output logic [ptr_width(DEPTH):0]     o_count,
    output logic                          o_full,
    output logic                          o_empty,
    output logic                          o_ovf,
    output logic                          o_udf
);

    localparam int c_PW = ptr_width(DEPTH);
    localparam int c_CW = c_PW + 1;

    logic [c_PW-1:0] r_wr_ptr;
    logic [c_PW-1:0] r_rd_ptr;
    logic [c_CW-1:0] r_count;
    logic            r_ovf;
    logic            r_udf;

    logic            w_full;
    logic            w_empty;
    logic            w_wr_acc;
    logic            w_rd_acc;

    assign w_full   = (r_count == c_CW'(DEPTH));
    assign w_empty  = (r_count == '0);

    // Acceptance depends only on the own-side flag, so a full FIFO still
    // drains on wr_en+rd_en and an empty FIFO still fills.
    assign w_wr_acc = i_wr_en && !w_full;
    assign w_rd_acc = i_rd_en && !w_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            r_ovf <= i_wr_en && w_full;
            r_udf <= i_rd_en && w_empty;
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + c_PW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + c_PW'(1);
            end
            if (w_wr_acc && !w_rd_acc) begin
                r_count <= r_count + c_CW'(1);
            end else if (w_rd_acc && !w_wr_acc) begin
                r_count <= r_count - c_CW'(1);
            end
        end
    end

    // Masked by rst so nothing lands in storage during a reset cycle.
    assign o_wr_accept = w_wr_acc && !rst;
    assign o_wr_ptr    = r_wr_ptr;
    assign o_rd_ptr    = r_rd_ptr;
    assign o_count     = r_count;
    assign o_full      = w_full;
    assign o_empty     = w_empty;
    assign o_ovf       = r_ovf;
    assign o_udf       = r_udf;

endmodule : fifo_ctrl
`default_nettype wire

// File: rtl/fifo_registros.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_registros
//  Description : Register-based synchronous FIFO, first-word-fall-through.
//  Ports       : clk   - clock, rising edge
//                rst   - synchronous active-high reset
//                wr_en - write request
//                d     - write data [N-1:0]
//                rd_en - read request (pops the head word)
//                q     - head word, zero while empty
//                full  - count == DEPTH
//                empty - count == 0
//                count - stored words [$clog2(DEPTH):0]
//                ovf   - one-cycle pulse after a rejected write
//                udf   - one-cycle pulse after a rejected read
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_registros
    import fifo_pkg::*;
#(
    parameter int N     = FIFO_N_DEF,
    parameter int DEPTH = FIFO_DEPTH_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      wr_en,
    input  logic [N-1:0]              d,
    input  logic                      rd_en,
    output logic [N-1:0]              q,
    output logic                      full,
    output logic                      empty,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      ovf,
    output logic                      udf
);

    localparam int c_PW = ptr_width(DEPTH);

    logic [N-1:0]    r_mem [DEPTH];
    logic            w_wr_accept;
    logic [c_PW-1:0] w_wr_ptr;
    logic [c_PW-1:0] w_rd_ptr;
    logic            w_empty;

    fifo_ctrl #(
        .DEPTH (DEPTH)
    ) u_ctrl (
        .clk         (clk),
        .rst         (rst),
        .i_wr_en     (wr_en),
        .i_rd_en     (rd_en),
        .o_wr_accept (w_wr_accept),
        .o_wr_ptr    (w_wr_ptr),
        .o_rd_ptr    (w_rd_ptr),
        .o_count     (count),
        .o_full      (full),
        .o_empty     (w_empty),
        .o_ovf       (ovf),
        .o_udf       (udf)
    );

    // Storage is intentionally not reset; the pointers/count define validity.
    always_ff @(posedge clk) begin
        if (w_wr_accept) begin
            r_mem[w_wr_ptr] <= d;
        end
    end

    // Stale storage never leaks out: q is forced to zero while empty.
    assign q     = w_empty ? '0 : r_mem[w_rd_ptr];
    assign empty = w_empty;

endmodule : fifo_registros
`default_nettype wire

// File: doc/fifo_registros.md
FIFO_REGISTROS -- requirements
Module: fifo_registros

Interface
REQ-001 The block SHALL have parameter N, default 8, data word width in bits (N >= 1).
REQ-002 The block SHALL have parameter DEPTH, default 4, number of storage words (power of two, DEPTH >= 2).
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-005 The block SHALL have port wr_en, input, 1, write request.
REQ-006 The block SHALL have port d, input, N, write data.
REQ-007 The block SHALL have port rd_en, input, 1, read request (pop of head word).
REQ-008 The block SHALL have port q, output, N, head word (first-word-fall-through).
REQ-009 The block SHALL have port full, output, 1, high when count == DEPTH.
REQ-010 The block SHALL have port empty, output, 1, high when count == 0.
REQ-011 The block SHALL have port count, output, $clog2(DEPTH)+1, number of stored words.
REQ-012 The block SHALL have port ovf, output, 1, one-cycle pulse on a rejected write.
REQ-013 The block SHALL have port udf, output, 1, one-cycle pulse on a rejected read.

Function
REQ-014 An accepted write SHALL store d at the write pointer and advance the pointer by 1, modulo DEPTH.
REQ-015 An accepted read SHALL advance the read pointer by 1, modulo DEPTH; the data is the value of q in that same cycle.
REQ-016 q SHALL be the word at the read pointer when not empty, and all-zeros when empty.
REQ-017 A write SHALL be accepted iff wr_en && !full, independent of rd_en.
REQ-018 A read SHALL be accepted iff rd_en && !empty, independent of wr_en.
REQ-019 Accepted write and accepted read in the same cycle SHALL leave count unchanged and move both pointers.
REQ-020 Count SHALL rise by 1 on write-only, fall by 1 on read-only, and otherwise hold.
REQ-021 When empty with wr_en && rd_en, only the write SHALL occur; q SHALL show the new word on the next cycle.
REQ-022 When full with wr_en && rd_en, only the read SHALL occur and the write is dropped.
REQ-023 ovf SHALL be registered high for exactly the cycle after a rejected write (wr_en && full); otherwise low.
REQ-024 udf SHALL be registered high for exactly the cycle after a rejected read (rd_en && empty); otherwise low.
REQ-025 Storage words SHALL be written only on accepted writes; stored contents SHALL never change otherwise.
REQ-026 full and empty SHALL be decoded combinationally from count; they SHALL never both be high.

Reset
REQ-027 At a rising clk edge with rst high, pointers, count, ovf and udf SHALL go to 0 regardless of wr_en/rd_en.
REQ-028 After reset, empty=1, full=0, count=0, q=0, ovf=0, udf=0; storage contents need not be cleared.
REQ-029 Reset asserted mid-operation SHALL discard all stored words; no write or read SHALL be accepted in the reset cycle.

Structure
REQ-030 A shared package fifo_pkg SHALL hold the default constants FIFO_N_DEF=8 and FIFO_DEPTH_DEF=4, and the pointer-width helper.
REQ-031 Pointer, count and flag logic SHALL live in one sub-module fifo_ctrl; storage and q mux stay in fifo_registros.

Verification
REQ-032 Reset, then write 0x11,0x22,0x33,0x44 (DEPTH=4) -> full=1, count=4, q=0x11 throughout.
REQ-033 Full FIFO, wr_en with d=0x55 -> ovf pulses 1 cycle, count stays 4; 4 reads return 0x11,0x22,0x33,0x44 in order.
REQ-034 Empty FIFO, rd_en -> udf pulses 1 cycle, count=0, q=0; then wr_en+rd_en together with d=0xA5 -> count=1, q=0xA5.
REQ-035 count=2, 6 consecutive cycles of wr_en+rd_en with incrementing data -> count stays 2, pointers wrap, output order preserved.
REQ-036 count=3, rst for 1 cycle with wr_en=1 -> count=0, empty=1, q=0, no word stored.
